muldiv_wb_queue: RTL and testbench
==================================

MULDIV_WB_QUEUE -- requirements
Module: muldiv_wb_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of completion entries; power of two, minimum 2.
REQ-002 Widths `XLEN, `HART_ID_W and `REG_ADDR_W SHALL come from defines.vh; NHART = 2**`HART_ID_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 muldiv_done  input  1  completion strobe from the mul/div unit, one cycle per result.
REQ-006 muldiv_result  input  `XLEN  result value.
REQ-007 muldiv_done_hart_id  input  `HART_ID_W  owning hart.
REQ-008 muldiv_done_rd  input  `REG_ADDR_W  destination register.
REQ-009 wb_valid  output  1  head entry presented to the regfile write port.
REQ-010 wb_ready  input  1  write port free this cycle (pipeline writeback not using it).
REQ-011 wb_hart_id / wb_rd / wb_data  output  `HART_ID_W / `REG_ADDR_W / `XLEN  head entry fields.
REQ-012 wbq_almost_full  output  1  count >= DEPTH-1; cpu_top gates muldiv_start with it.
REQ-013 hart_pending  output  NHART  bit h set while any queued entry belongs to hart h.
REQ-014 wbq_overflow  output  1  sticky error flag.

Function
REQ-015 Push SHALL occur when muldiv_done=1 and muldiv_done_rd!=0; completions to x0 SHALL be discarded with no state change.
REQ-016 Pop SHALL occur when wb_valid=1 and wb_ready=1.
REQ-017 Storage SHALL be a circular FIFO with read/write pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-018 Ordering SHALL be strict FIFO across all harts.
REQ-019 Without bypass, a push SHALL appear on wb_valid the cycle after muldiv_done, a minimum latency of 1.
REQ-020 wb_valid SHALL equal (count != 0), plus the bypass term of REQ-030.
REQ-021 wb_* outputs SHALL hold stable while wb_valid=1 and wb_ready=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; this SHALL be legal when full.
REQ-023 A push when count==DEPTH with no pop SHALL drop the entry, set wbq_overflow and leave the FIFO unchanged.
REQ-024 A pop when empty SHALL NOT occur, because wb_valid=0.
REQ-025 hart_pending SHALL be derived from per-hart counters of width clog2(DEPTH+1).
REQ-026 A per-hart counter SHALL increment on push and decrement on pop for the matching hart; it SHALL be unchanged when push and pop hit the same hart.
REQ-027 wbq_almost_full SHALL be registered-state derived, not combinational from muldiv_done.

Reset
REQ-028 rst_n low SHALL clear pointers, count, per-hart counters and wbq_overflow immediately, regardless of clk; wb_valid=0, hart_pending=0, wbq_almost_full=0.
REQ-029 Reset mid-operation SHALL discard all queued entries; wb_data/wb_rd/wb_hart_id are don't-care while wb_valid=0, but the bench SHALL see 0 after reset.

Configuration
REQ-030 With MULDIV_WBQ_BYPASS_EN defined: when count==0 and push occurs with wb_ready=1, the entry SHALL drive wb_* combinationally in the same cycle, wb_valid=1, and SHALL NOT be enqueued; hart_pending is unaffected.
REQ-031 Without MULDIV_WBQ_BYPASS_EN: every accepted completion SHALL pass through storage (REQ-019); no combinational path from muldiv_* to wb_*.

Verification
REQ-032 Scenario 1: single completion (hart0, rd=3, 30) with wb_ready=1 -> wb_valid next cycle with rd=3, data=30; hart_pending[0] pulses 1 cycle; with bypass, same cycle and hart_pending stays 0.
REQ-033 Scenario 2: rd=0 completion, value 0xDEAD -> no wb_valid, count 0.
REQ-034 Scenario 3: wb_ready=0, completions 3 (rd4), 1 (rd5), 7 (rd6), 9 (rd7) with DEPTH=4 -> almost_full after third push; fifth push sets wbq_overflow; release drains 3,1,7,9 in order.
REQ-035 Scenario 4: full queue, push and pop in the same cycle -> count stays 4, new entry last, no overflow.
REQ-036 Scenario 5: interleaved hart0/hart1 completions -> hart_pending bits track each hart, clearing when its last entry pops.
REQ-037 Scenario 6: assert rst_n low mid-cycle with 3 entries queued -> outputs clear before the next edge; overflow cleared.

Source files
------------

// File: rtl/muldiv_wb_queue_if.sv
// Completion-in / writeback-out bundle for muldiv_wb_queue.
// master = the queue, slave = producer/consumer side.
`include "defines.vh"

interface muldiv_wb_queue_if;
  logic                   muldiv_done;
  logic [`XLEN-1:0]       muldiv_result;
  logic [`HART_ID_W-1:0]  muldiv_done_hart_id;
  logic [`REG_ADDR_W-1:0] muldiv_done_rd;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [`HART_ID_W-1:0]  wb_hart_id;
  logic [`REG_ADDR_W-1:0] wb_rd;
  logic [`XLEN-1:0]       wb_data;

  modport master (
    input  muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd, wb_ready,
    output wb_valid, wb_hart_id, wb_rd, wb_data
  );
  modport slave (
    output muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd, wb_ready,
    input  wb_valid, wb_hart_id, wb_rd, wb_data
  );
endinterface

// File: rtl/defines.vh
// Shared datapath widths for the mul/div writeback path.
`ifndef MULDIV_DEFINES_VH
`define MULDIV_DEFINES_VH
`define XLEN       32
`define HART_ID_W  1
`define REG_ADDR_W 5
`endif

// File: rtl/muldiv_wb_queue.sv
// Strict-FIFO completion queue between the mul/div unit and the regfile write port.
// Optional same-cycle bypass when empty: define MULDIV_WBQ_BYPASS_EN.
`include "defines.vh"

module muldiv_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  muldiv_wb_queue_if.master             bus,
  output logic                          wbq_almost_full,
  output logic [(1<<`HART_ID_W)-1:0]    hart_pending,
  output logic                          wbq_overflow
);
  localparam int unsigned NHART = 1 << `HART_ID_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [`HART_ID_W-1:0]  hart;
    logic [`REG_ADDR_W-1:0] rd;
    logic [`XLEN-1:0]       data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   hcnt_q [NHART];
  logic [CNT_W-1:0]   hcnt_d [NHART];
  logic               ovf_q, ovf_d;

  entry_t in_entry, head;
  logic   push, bypass, push_q, pop, full, wr_en;

  assign in_entry = '{hart: bus.muldiv_done_hart_id, rd: bus.muldiv_done_rd, data: bus.muldiv_result};
  assign head     = mem_q[rd_ptr_q];
  assign push     = bus.muldiv_done && (bus.muldiv_done_rd != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop      = (count_q != '0) && bus.wb_ready;

`ifdef MULDIV_WBQ_BYPASS_EN
  assign bypass   = push && (count_q == '0) && bus.wb_ready;
`else
  assign bypass   = 1'b0;
`endif

  assign push_q   = push && !bypass;
  // Full queue still accepts when the head leaves in the same cycle.
  assign wr_en    = push_q && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !wr_en) count_d = count_q - CNT_W'(1);
    if (push_q && full && !pop) ovf_d = 1'b1;
    for (int unsigned h = 0; h < NHART; h++) begin
      hcnt_d[h] = hcnt_q[h];
      if (wr_en && (in_entry.hart == `HART_ID_W'(h))) hcnt_d[h] = hcnt_d[h] + CNT_W'(1);
      if (pop && (head.hart == `HART_ID_W'(h)))       hcnt_d[h] = hcnt_d[h] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned h = 0; h < NHART; h++) hcnt_q[h] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      for (int unsigned h = 0; h < NHART; h++) hcnt_q[h] <= hcnt_d[h];
    end
  end

  // Storage needs no reset: outputs are masked to zero whenever wb_valid is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_entry;
  end

  entry_t out_entry;
  logic   out_valid;

  always_comb begin
    out_valid = (count_q != '0);
    out_entry = out_valid ? head : '0;
    if (bypass) begin
      out_valid = 1'b1;
      out_entry = in_entry;
    end
  end

  assign bus.wb_valid   = out_valid;
  assign bus.wb_hart_id = out_entry.hart;
  assign bus.wb_rd      = out_entry.rd;
  assign bus.wb_data    = out_entry.data;

  assign wbq_almost_full = (count_q >= CNT_W'(DEPTH - 1));
  assign wbq_overflow    = ovf_q;

  always_comb begin
    hart_pending = '0;
    for (int unsigned h = 0; h < NHART; h++) hart_pending[h] = (hcnt_q[h] != '0);
  end
endmodule

// File: tb/tb_muldiv_wb_queue.sv
// Directed table-driven bench for muldiv_wb_queue (DEPTH=4, two harts).
`include "defines.vh"

module tb_muldiv_wb_queue;
  localparam int XW = `XLEN;
  localparam int HW = `HART_ID_W;
  localparam int RW = `REG_ADDR_W;
  localparam int NH = 1 << `HART_ID_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          af, ovf;
  logic [NH-1:0] pend;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_wb_queue_if bus_if ();

  muldiv_wb_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus_if),
    .wbq_almost_full (af),
    .hart_pending    (pend),
    .wbq_overflow    (ovf)
  );

  typedef struct {
    logic          done;
    logic [HW-1:0] hart;
    logic [RW-1:0] rd;
    logic [XW-1:0] data;
    logic          ready;
    logic          ev;
    logic [RW-1:0] erd;
    logic [XW-1:0] edata;
    logic [HW-1:0] ehart;
    logic          eaf;
    logic [NH-1:0] epend;
    logic          eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic done, int hart, int rd, int data, logic ready,
                              logic ev, int erd, int edata, int ehart,
                              logic eaf, int epend, logic eovf);
    vec_t v;
    v.done = done;  v.hart = HW'(hart);   v.rd = RW'(rd);     v.data = XW'(data);
    v.ready = ready; v.ev = ev;           v.erd = RW'(erd);   v.edata = XW'(edata);
    v.ehart = HW'(ehart); v.eaf = eaf;    v.epend = NH'(epend); v.eovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic done, input int hart, input int rd, input int data, input logic ready);
    bus_if.muldiv_done         = done;
    bus_if.muldiv_done_hart_id = HW'(hart);
    bus_if.muldiv_done_rd      = RW'(rd);
    bus_if.muldiv_result       = XW'(data);
    bus_if.wb_ready            = ready;
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 1'b0);

    // done hart rd data rdy | valid rd data hart af pend ovf
    vecs.push_back(mk(0,0,0,0,1,        0,0,0,0,      0,0,0));
`ifdef MULDIV_WBQ_BYPASS_EN
    vecs.push_back(mk(1,0,3,30,1,       1,3,30,0,     0,0,0));
    vecs.push_back(mk(0,0,0,0,1,        0,0,0,0,      0,0,0));
`else
    vecs.push_back(mk(1,0,3,30,1,       0,0,0,0,      0,0,0));
    vecs.push_back(mk(0,0,0,0,1,        1,3,30,0,     0,1,0));
`endif
    vecs.push_back(mk(0,0,0,0,1,        0,0,0,0,      0,0,0));
    vecs.push_back(mk(1,0,0,'hDEAD,1,   0,0,0,0,      0,0,0));
    vecs.push_back(mk(0,0,0,0,1,        0,0,0,0,      0,0,0));
    vecs.push_back(mk(1,0,4,3,0,        0,0,0,0,      0,0,0));
    vecs.push_back(mk(1,1,5,1,0,        1,4,3,0,      0,1,0));
    vecs.push_back(mk(1,0,6,7,0,        1,4,3,0,      0,3,0));
    vecs.push_back(mk(1,1,7,9,0,        1,4,3,0,      1,3,0));
    vecs.push_back(mk(1,0,8,11,0,       1,4,3,0,      1,3,0));
    vecs.push_back(mk(0,0,0,0,0,        1,4,3,0,      1,3,1));
    vecs.push_back(mk(1,1,9,13,1,       1,4,3,0,      1,3,1));
    vecs.push_back(mk(0,0,0,0,1,        1,5,1,1,      1,3,1));
    vecs.push_back(mk(0,0,0,0,1,        1,6,7,0,      1,3,1));
    vecs.push_back(mk(0,0,0,0,1,        1,7,9,1,      0,2,1));
    vecs.push_back(mk(0,0,0,0,1,        1,9,13,1,     0,2,1));
    vecs.push_back(mk(0,0,0,0,1,        0,0,0,0,      0,0,1));
    vecs.push_back(mk(1,1,10,'h21,0,    0,0,0,0,      0,0,1));
    vecs.push_back(mk(1,0,11,'h22,0,    1,10,'h21,1,  0,2,1));
    vecs.push_back(mk(1,1,12,'h23,1,    1,10,'h21,1,  0,3,1));
    vecs.push_back(mk(0,0,0,0,1,        1,11,'h22,0,  0,3,1));
    vecs.push_back(mk(0,0,0,0,1,        1,12,'h23,1,  0,2,1));
    vecs.push_back(mk(0,0,0,0,1,        0,0,0,0,      0,0,1));

    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].done, int'(vecs[i].hart), int'(vecs[i].rd), int'(vecs[i].data), vecs[i].ready);
      #2;
      check($sformatf("v%0d.valid", i), 32'(bus_if.wb_valid),   32'(vecs[i].ev));
      check($sformatf("v%0d.rd",    i), 32'(bus_if.wb_rd),      32'(vecs[i].erd));
      check($sformatf("v%0d.data",  i), 32'(bus_if.wb_data),    32'(vecs[i].edata));
      check($sformatf("v%0d.hart",  i), 32'(bus_if.wb_hart_id), 32'(vecs[i].ehart));
      check($sformatf("v%0d.af",    i), 32'(af),                32'(vecs[i].eaf));
      check($sformatf("v%0d.pend",  i), 32'(pend),              32'(vecs[i].epend));
      check($sformatf("v%0d.ovf",   i), 32'(ovf),               32'(vecs[i].eovf));
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-cycle with three entries queued.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, k % 2, 20 + k, 100 + k, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, 0, 0, 0, 1'b0);
    #1;
    check("rst.pre_valid", 32'(bus_if.wb_valid), 32'd1);
    check("rst.pre_af",    32'(af),              32'd1);
    check("rst.pre_ovf",   32'(ovf),             32'd1);
    check("rst.pre_data",  32'(bus_if.wb_data),  32'd100);
    #2 rst_n = 1'b0;
    #1;
    check("rst.valid", 32'(bus_if.wb_valid),   32'd0);
    check("rst.pend",  32'(pend),              32'd0);
    check("rst.af",    32'(af),                32'd0);
    check("rst.ovf",   32'(ovf),               32'd0);
    check("rst.data",  32'(bus_if.wb_data),    32'd0);
    check("rst.rd",    32'(bus_if.wb_rd),      32'd0);
    check("rst.hart",  32'(bus_if.wb_hart_id), 32'd0);
    @(posedge clk); #1;
    check("rst.hold_valid", 32'(bus_if.wb_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Queue is usable again after reset: one completion arrives within a bounded wait.
    begin
      int waited = 0;
      drive(1'b1, 1, 13, 'h55, 1'b1);
      #1;
      while (!bus_if.wb_valid && waited < 4) begin
        @(posedge clk); #1;
        drive(1'b0, 0, 0, 0, 1'b1);
        #1;
        waited++;
      end
`ifdef MULDIV_WBQ_BYPASS_EN
      check("post.latency", 32'(waited), 32'd0);
`else
      check("post.latency", 32'(waited), 32'd1);
      check("post.pend",    32'(pend),   32'd2);
`endif
      check("post.valid", 32'(bus_if.wb_valid), 32'd1);
      check("post.rd",    32'(bus_if.wb_rd),    32'd13);
      check("post.data",  32'(bus_if.wb_data),  32'h55);
      drive(1'b0, 0, 0, 0, 1'b1);
      @(posedge clk); #1;
      check("post.drained", 32'(bus_if.wb_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
